// File: rtl/sd_spi_arbiter_if.sv
// -----------------------------------------------------------------------------
// sd_spi_arbiter_if
// Bundles the request/acknowledge handshakes of the two requesters (CPU port 0,
// loader engine 1), the status outputs and the SD card SPI pins of
// sd_spi_arbiter.
//   slave  : view used by the arbiter (requests and miso in; acks, status and
//            SPI pins out)
//   master : view used by whatever drives the requesters and the card
// The clock and reset are not part of the bundle.
// -----------------------------------------------------------------------------
interface sd_spi_arbiter_if;
    logic       ck7;        // clock-enable strobe, one clk28 cycle in four
    logic       r0_req;
    logic       r1_req;
    logic [7:0] r0_wdata;
    logic [7:0] r1_wdata;
    logic       r0_cs_n;
    logic       r1_cs_n;
    logic       r1_lock;    // loader keeps ownership across transfers
    logic       r0_ack;
    logic       r1_ack;
    logic [7:0] rdata;
    logic       owner;
    logic       busy;
    logic       r0_wait;
    logic       sd_sck;
    logic       sd_mosi;
    logic       sd_cs;
    logic       sd_miso;

    modport slave (
        input  ck7, r0_req, r1_req, r0_wdata, r1_wdata, r0_cs_n, r1_cs_n,
               r1_lock, sd_miso,
        output r0_ack, r1_ack, rdata, owner, busy, r0_wait, sd_sck, sd_mosi,
               sd_cs
    );

    modport master (
        output ck7, r0_req, r1_req, r0_wdata, r1_wdata, r0_cs_n, r1_cs_n,
               r1_lock, sd_miso,
        input  r0_ack, r1_ack, rdata, owner, busy, r0_wait, sd_sck, sd_mosi,
               sd_cs
    );
endinterface

// File: rtl/sd_spi_arbiter.sv
// -----------------------------------------------------------------------------
// sd_spi_arbiter
// Shares one SD card SPI port (mode 0, MSB first) between two byte requesters.
// Arbitration is round-robin (RR=1) or fixed priority with requester 0 winning
// (RR=0). The loader (requester 1) can lock the bus across transfers with
// r1_lock. Each byte runs IDLE -> LOAD -> SHIFT -> DONE; every SPI bit uses two
// ck7 strobes (rise + sample, then fall + shift).
// Ports:
//   clk28 : system clock
//   rst   : synchronous active-high reset
//   bus   : sd_spi_arbiter_if.slave (requests, acks, status, SPI pins)
// -----------------------------------------------------------------------------
module sd_spi_arbiter #(
    parameter bit RR        = 1'b1,
    parameter bit IDLE_MOSI = 1'b1
) (
    input  logic            clk28,
    input  logic            rst,
    sd_spi_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_owner;    // requester that owns the current/last byte
    logic       r_last;     // last granted requester (round-robin pointer)
    logic       r_granted;  // a grant has happened since reset
    logic       r_phase;    // 0: next strobe raises sck, 1: next strobe lowers it
    logic       r_sck;
    logic       r_miso;     // bit sampled on the rising strobe
    logic [7:0] r_shift;
    logic [7:0] r_rdata;
    logic [2:0] r_bitcnt;

    logic       w_want0;
    logic       w_want1;
    logic       w_grant;
    logic       w_winner;
    logic       w_last_fall;
    logic       w_ack0;
    logic       w_ack1;

    // While the locked loader owns the bus, requester 0 is not eligible.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise a latch is inferred.
    always_comb begin
        w_want0  = bus.r0_req && !(bus.r1_lock && r_owner);
        w_want1  = bus.r1_req;
        w_grant  = w_want0 || w_want1;
        w_winner = 1'b0;
        if (w_want0 && w_want1)
            w_winner = RR ? !r_last : 1'b0;
        else if (w_want1)
            w_winner = 1'b1;
    end

    assign w_last_fall = (r_state == S_SHIFT) && bus.ck7 && r_phase &&
                         (r_bitcnt == 3'd7);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the clock edge.
    always_ff @(posedge clk28) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (w_last_fall) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: ownership, shift register and SPI clock generation.
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_last    <= 1'b1;     // first contest after reset goes to requester 0
            r_granted <= 1'b0;
            r_phase   <= 1'b0;
            r_sck     <= 1'b0;
            r_miso    <= 1'b0;
            r_shift   <= 8'h00;
            r_rdata   <= 8'h00;
            r_bitcnt  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Ownership only moves here, so sd_cs never switches mid-byte.
                    if (w_grant) begin
                        r_owner   <= w_winner;
                        r_last    <= w_winner;
                        r_granted <= 1'b1;
                        r_shift   <= w_winner ? bus.r1_wdata : bus.r0_wdata;
                    end
                end
                S_LOAD: begin
                    r_bitcnt <= 3'd0;
                    r_phase  <= 1'b0;
                    r_sck    <= 1'b0;
                end
                S_SHIFT: begin
                    if (bus.ck7) begin
                        if (!r_phase) begin
                            r_sck   <= 1'b1;
                            r_miso  <= bus.sd_miso;
                            r_phase <= 1'b1;
                        end else begin
                            r_sck    <= 1'b0;
                            r_phase  <= 1'b0;
                            r_shift  <= {r_shift[6:0], r_miso};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            // The received byte becomes visible as DONE starts.
                            if (r_bitcnt == 3'd7)
                                r_rdata <= {r_shift[6:0], r_miso};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        w_ack0       = (r_state == S_DONE) && !r_owner;
        w_ack1       = (r_state == S_DONE) &&  r_owner;
        bus.r0_ack   = w_ack0;
        bus.r1_ack   = w_ack1;
        bus.busy     = (r_state != S_IDLE);
        bus.owner    = r_owner;
        bus.rdata    = r_rdata;
        bus.r0_wait  = bus.r0_req && !w_ack0;
        bus.sd_sck   = r_sck;
        bus.sd_mosi  = (r_state == S_LOAD || r_state == S_SHIFT) ? r_shift[7]
                                                                 : IDLE_MOSI;
        // Chip select follows the owner's input live; deselected until the
        // first grant after reset.
        bus.sd_cs    = r_granted ? (r_owner ? bus.r1_cs_n : bus.r0_cs_n) : 1'b1;
    end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_spi_arbiter
// Runs a round-robin instance (RR=1) and a fixed-priority instance (RR=0) side
// by side. Expected transfers (requester, transmitted byte, received byte) are
// queued per instance when stimulus is issued; a monitor pops and compares on
// every ack and also models the SD card on the SPI pins.
// -----------------------------------------------------------------------------
module tb_sd_spi_arbiter;

    typedef struct packed {
        logic       who;
        logic [7:0] tx;
        logic [7:0] rx;
        logic       lp;     // card loops mosi back to miso
    } exp_t;

    localparam logic R0_CSN = 1'b0;
    localparam logic R1_CSN = 1'b1;

    logic clk28   = 1'b0;
    logic rst     = 1'b1;
    logic ck7     = 1'b0;
    logic r1_lock = 1'b0;
    int   ck_cnt  = 0;

    // Requester models: requester i of instance d has sent k[d][i] of wlen[i].
    logic [7:0] wlist [2][16];
    logic [4:0] wlen  [2];
    logic [4:0] k     [2][2];

    exp_t q0[$];
    exp_t q1[$];

    int   n_tests = 0;
    int   n_fail  = 0;

    logic       model_last [2];
    logic       miso       [2];
    int         idx        [2];
    int         ncap       [2];
    int         lat        [2];
    logic [7:0] cap        [2];
    logic [7:0] last_rdata [2];
    logic       prev_sck   [2];
    logic       granted    [2];

    sd_spi_arbiter_if u_if0 ();
    sd_spi_arbiter_if u_if1 ();

    sd_spi_arbiter #(.RR(1'b1), .IDLE_MOSI(1'b1)) dut_rr (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (u_if0)
    );

    sd_spi_arbiter #(.RR(1'b0), .IDLE_MOSI(1'b1)) dut_fp (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (u_if1)
    );

    assign u_if0.ck7      = ck7;
    assign u_if0.r1_lock  = r1_lock;
    assign u_if0.r0_cs_n  = R0_CSN;
    assign u_if0.r1_cs_n  = R1_CSN;
    assign u_if0.r0_req   = (k[0][0] < wlen[0]);
    assign u_if0.r1_req   = (k[0][1] < wlen[1]);
    assign u_if0.r0_wdata = wlist[0][k[0][0][3:0]];
    assign u_if0.r1_wdata = wlist[1][k[0][1][3:0]];
    assign u_if0.sd_miso  = miso[0];

    assign u_if1.ck7      = ck7;
    assign u_if1.r1_lock  = r1_lock;
    assign u_if1.r0_cs_n  = R0_CSN;
    assign u_if1.r1_cs_n  = R1_CSN;
    assign u_if1.r0_req   = (k[1][0] < wlen[0]);
    assign u_if1.r1_req   = (k[1][1] < wlen[1]);
    assign u_if1.r0_wdata = wlist[0][k[1][0][3:0]];
    assign u_if1.r1_wdata = wlist[1][k[1][1][3:0]];
    assign u_if1.sd_miso  = miso[1];

    logic       m_ack0  [2];
    logic       m_ack1  [2];
    logic       m_busy  [2];
    logic       m_sck   [2];
    logic       m_mosi  [2];
    logic       m_cs    [2];
    logic       m_owner [2];
    logic       m_wait  [2];
    logic [7:0] m_rdata [2];

    assign m_ack0[0]  = u_if0.r0_ack;   assign m_ack0[1]  = u_if1.r0_ack;
    assign m_ack1[0]  = u_if0.r1_ack;   assign m_ack1[1]  = u_if1.r1_ack;
    assign m_busy[0]  = u_if0.busy;     assign m_busy[1]  = u_if1.busy;
    assign m_sck[0]   = u_if0.sd_sck;   assign m_sck[1]   = u_if1.sd_sck;
    assign m_mosi[0]  = u_if0.sd_mosi;  assign m_mosi[1]  = u_if1.sd_mosi;
    assign m_cs[0]    = u_if0.sd_cs;    assign m_cs[1]    = u_if1.sd_cs;
    assign m_owner[0] = u_if0.owner;    assign m_owner[1] = u_if1.owner;
    assign m_wait[0]  = u_if0.r0_wait;  assign m_wait[1]  = u_if1.r0_wait;
    assign m_rdata[0] = u_if0.rdata;    assign m_rdata[1] = u_if1.rdata;

    initial forever #5 clk28 = ~clk28;

    initial forever begin
        @(posedge clk28);
        #1;
        ck7    = (ck_cnt == 3);
        ck_cnt = (ck_cnt + 1) % 4;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Monitor + card model + requester reaction to acks.
    always @(negedge clk28) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                logic has;
                has = (qsize(d) > 0);
                e   = has ? qfront(d) : '0;

                if (m_sck[d] && !prev_sck[d]) begin
                    cap[d]  = {cap[d][6:0], m_mosi[d]};
                    ncap[d] = ncap[d] + 1;
                end
                if (!m_sck[d] && prev_sck[d])
                    idx[d] = idx[d] + 1;
                prev_sck[d] = m_sck[d];

                if (m_busy[d]) begin
                    lat[d]     = lat[d] + 1;
                    granted[d] = 1'b1;
                    if (has) check("cs_follows_owner", m_cs[d], e.who ? R1_CSN : R0_CSN);
                    else     check("busy_without_request", m_busy[d], 0);
                end else begin
                    check("sck_idle_low", m_sck[d], 0);
                    check("mosi_idle_level", m_mosi[d], 1);
                    if (!granted[d]) check("cs_before_first_grant", m_cs[d], 1);
                end

                if (m_ack0[d] || m_ack1[d]) begin
                    if (!has) begin
                        check("unexpected_ack", {m_ack0[d], m_ack1[d]}, 0);
                    end else begin
                        check("ack_requester", m_ack1[d], e.who);
                        check("single_ack", m_ack0[d] & m_ack1[d], 0);
                        check("owner_at_ack", m_owner[d], e.who);
                        check("rdata", m_rdata[d], e.lp ? e.tx : e.rx);
                        check("mosi_byte", cap[d], e.tx);
                        check("sck_rises", ncap[d], 8);
                        check("grant_to_ack_le_66", lat[d] <= 66, 1);
                        last_rdata[d] = e.lp ? e.tx : e.rx;
                        qpop(d);
                    end
                    if (m_ack0[d]) k[d][0] = k[d][0] + 5'd1;
                    if (m_ack1[d]) k[d][1] = k[d][1] + 5'd1;
                    cap[d]  = 8'h00;
                    ncap[d] = 0;
                    idx[d]  = 0;
                    lat[d]  = 0;
                end else begin
                    check("rdata_hold", m_rdata[d], last_rdata[d]);
                end

                // Card drives the bit for the next rising strobe.
                if (qsize(d) > 0) begin
                    e = qfront(d);
                    if (e.lp)          miso[d] = m_mosi[d];
                    else if (idx[d] < 8) miso[d] = e.rx[3'(7 - idx[d])];
                    else               miso[d] = 1'b1;
                end else begin
                    miso[d] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk28);
        #2;
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        wlen[0] = 5'd0;
        wlen[1] = 5'd0;
        for (int d = 0; d < 2; d++) begin
            k[d][0]       = 5'd0;
            k[d][1]       = 5'd0;
            model_last[d] = 1'b1;
            miso[d]       = 1'b1;
            idx[d]        = 0;
            ncap[d]       = 0;
            lat[d]        = 0;
            cap[d]        = 8'h00;
            last_rdata[d] = 8'h00;
            prev_sck[d]   = 1'b0;
            granted[d]    = 1'b0;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++)
                wlist[i][j] = 8'($urandom);
    endtask

    // Reference order: round-robin alternates while both still want bytes,
    // starting with the one not granted last; fixed priority drains 0 first.
    task automatic issue(input int n0, input int n1, input logic lp);
        for (int d = 0; d < 2; d++) begin
            int   c0 = 0;
            int   c1 = 0;
            logic w;
            exp_t e;
            while (c0 < n0 || c1 < n1) begin
                if (c0 < n0 && c1 < n1) w = (d == 0) ? !model_last[d] : 1'b0;
                else                    w = (c0 < n0) ? 1'b0 : 1'b1;
                e.who = w;
                e.tx  = w ? wlist[1][c1] : wlist[0][c0];
                e.rx  = 8'($urandom);
                e.lp  = lp;
                qpush(d, e);
                model_last[d] = w;
                if (w) c1++; else c0++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            k[d][0] = 5'd0;
            k[d][1] = 5'd0;
        end
        wlen[0] = 5'(n0);
        wlen[1] = 5'(n1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy[0] || m_busy[1]) &&
               n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", n < budget, 1);
        tick();
    endtask

    task automatic wait_k(input int i, input int target, input int budget);
        int n = 0;
        while (int'(k[0][i]) < target && n < budget) begin
            tick();
            n++;
        end
        check("ack_count_within_budget", int'(k[0][i]) >= target, 1);
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", m_busy[d], 0);
            check("rst_sck", m_sck[d], 0);
            check("rst_cs", m_cs[d], 1);
            check("rst_mosi", m_mosi[d], 1);
            check("rst_owner", m_owner[d], 0);
            check("rst_rdata", m_rdata[d], 0);
            check("rst_acks", {m_ack0[d], m_ack1[d]}, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        check_reset_state();
    endtask

    initial begin
        int rises;
        logic prev;
        int n;

        clear_model();
        fill_random();
        tick();
        do_reset();

        // Loopback byte A5 from requester 0.
        fill_random();
        wlist[0][0] = 8'hA5;
        issue(1, 0, 1'b1);
        wait_idle(500);

        // Simultaneous requests, two bytes each, fresh from reset.
        do_reset();
        fill_random();
        issue(2, 2, 1'b0);
        wait_idle(1000);

        // Random batches of requests.
        for (int it = 0; it < 12; it++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 3));
            b = int'($urandom_range(0, 3));
            if (a == 0 && b == 0) a = 1;
            fill_random();
            issue(a, b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) tick();
            wait_idle(2000);
        end

        // Locked loader: r0 waits until the lock drops and the byte in flight acks.
        fill_random();
        r1_lock = 1'b1;
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.lp = 1'b0;
            for (int j = 0; j < 5; j++) begin
                e.who = (j == 3) ? 1'b0 : 1'b1;
                e.tx  = (j == 3) ? wlist[0][0] : wlist[1][(j == 4) ? 3 : j];
                e.rx  = 8'($urandom);
                qpush(d, e);
            end
            model_last[d] = 1'b1;
            k[d][0] = 5'd0;
            k[d][1] = 5'd0;
        end
        wlen[0] = 5'd0;
        wlen[1] = 5'd4;
        wait_k(1, 1, 300);
        wlen[0] = 5'd1;
        wait_k(1, 2, 300);
        repeat (20) begin
            tick();
            check("r0_wait_rr_locked", m_wait[0], 1);
            check("r0_wait_fp_locked", m_wait[1], 1);
        end
        r1_lock = 1'b0;
        wait_idle(1000);

        // Reset in the middle of a byte.
        fill_random();
        issue(1, 0, 1'b0);
        rises = 0;
        prev  = 1'b0;
        n     = 0;
        while (rises < 4 && n < 500) begin
            tick();
            n++;
            if (m_sck[0] && !prev) rises++;
            prev = m_sck[0];
        end
        check("fourth_sck_rise_seen", rises, 4);
        rst = 1'b1;
        clear_model();
        tick();
        rst = 1'b0;
        check_reset_state();
        fill_random();
        issue(1, 1, 1'b0);
        wait_idle(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_arbiter.md
SD_SPI_ARBITER -- requirements
Module: sd_spi_arbiter

Interface
REQ-001 Parameter RR, default 1: 1 = round-robin arbitration between requesters; 0 = fixed priority, requester 0 wins.
REQ-002 Parameter IDLE_MOSI, default 1: sd_mosi level whenever no byte is shifting.
REQ-003 clk28  in  1  system clock; single clock domain.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ck7  in  1  clock-enable strobe, one clk28 cycle in every 4.
REQ-006 r0_req / r1_req  in  1  level transfer request from CPU port (0) or loader engine (1).
REQ-007 r0_wdata / r1_wdata  in  8  byte to transmit; sampled on grant.
REQ-008 r0_cs_n / r1_cs_n  in  1  requester's desired chip-select level.
REQ-009 r1_lock  in  1  loader holds bus ownership across transfers.
REQ-010 r0_ack / r1_ack  out  1  one-cycle pulse when that requester's byte completes.
REQ-011 rdata  out  8  received byte; valid from ack until next grant.
REQ-012 owner  out  1  current owner index.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 r0_wait  out  1  high while r0_req pending and not yet acked.
REQ-015 sd_sck, sd_mosi, sd_cs  out  1 each; sd_miso  in  1  SD card SPI pins.

Function
REQ-016 FSM states: IDLE, LOAD, SHIFT, DONE; encoding is implementation-defined.
REQ-017 IDLE: evaluate requests every clk28; on grant, latch owner, the winning wdata into the shift register, and move to LOAD.
REQ-018 Eligibility: while r1_lock=1 and owner=1, only requester 1 is eligible; otherwise both requesters are eligible.
REQ-019 RR=1: if both are eligible, grant the requester not granted last; the first contest after reset goes to 0.
REQ-020 RR=0: if both are eligible, grant requester 0.
REQ-021 LOAD: lasts one cycle; sd_mosi = shift_reg[7]; bit counter = 0; move to SHIFT.
REQ-022 SHIFT (SPI mode 0, MSB first): each bit uses two ck7 strobes.
  - First strobe: sd_sck rises and sd_miso is sampled.
  - Second strobe: sd_sck falls and the register shifts left, with the sampled bit entering bit 0.
REQ-023 After the 8th falling edge: go to DONE; rdata = shift register; sd_mosi returns to IDLE_MOSI.
REQ-024 DONE: lasts one cycle; pulse the owner's ack; go to IDLE.
REQ-025 Transfer length: grant to ack is 16 ck7 strobes plus 2 cycles, at most 66 clk28 cycles.
REQ-026 A req still high in the IDLE cycle after its ack starts a new transfer; requesters drop req on ack.
REQ-027 A req withdrawn before grant is dropped silently; a req change after grant does not affect the transfer in flight.
REQ-028 sd_cs = cs_n of the current owner, updated combinationally from that requester's input.
REQ-029 Ownership changes only in IDLE, so sd_cs never switches source mid-byte.
REQ-030 sd_sck = 0 outside SHIFT; sd_sck toggles only on ck7.
REQ-031 If r1_lock falls while requester 1 owns and the FSM is not IDLE, the current byte completes before requester 0 becomes eligible.
REQ-032 rdata holds its value across IDLE and changes only in DONE.

Reset
REQ-033 rst=1 at any clk28 edge, including mid-SHIFT, forces all of the following on the next edge:
  - FSM to IDLE.
  - sd_sck=0, sd_mosi=IDLE_MOSI, sd_cs=1.
  - owner=0, round-robin pointer = "last was 1".
  - rdata=0, acks=0, busy=0.
  - No partial byte is acked.
REQ-034 Before the first grant after reset, sd_cs = 1 regardless of r0_cs_n / r1_cs_n.

Verification
REQ-035 r0_req=1, wdata=A5, sd_miso looped to sd_mosi -> sd_mosi shows 1,0,1,0,0,1,0,1 on 8 sck rising edges; r0_ack once; rdata=A5; grant-to-ack at most 66 cycles.
REQ-036 r0_req and r1_req asserted in the same cycle with RR=1, each held for two bytes -> grant order 0,1,0,1; with RR=0 -> 0,0,1,1.
REQ-037 r1_lock=1 with owner=1 and r0_req held -> r0 is never granted and r0_wait stays 1; drop r1_lock -> r0 is granted after the in-flight byte acks.
REQ-038 rst pulsed at the 4th sck rising edge -> next cycle: sd_sck=0, sd_cs=1, busy=0; no ack pulse; a subsequent transfer completes normally.
REQ-039 r0_cs_n=0, r1_cs_n=1, alternating grants -> sd_cs follows the owner and never changes while busy=1.
